// File: rtl/qam_slicer_serdes_if.sv
// Sample-in / serial-bit-out handshake bundle for qam_slicer_serdes.
// The slave modport is the slicer's view; master is the upstream/downstream side.
interface qam_slicer_serdes_if #(
    parameter int SAMPLE_W = 8
);
    logic                       in_valid;
    logic                       in_ready;
    logic signed [SAMPLE_W-1:0] I_in;
    logic signed [SAMPLE_W-1:0] Q_in;
    logic                       bit_out;
    logic                       bit_valid;
    logic                       bit_ready;

    modport master (
        output in_valid, I_in, Q_in, bit_ready,
        input  in_ready, bit_out, bit_valid
    );

    modport slave (
        input  in_valid, I_in, Q_in, bit_ready,
        output in_ready, bit_out, bit_valid
    );
endinterface

// File: rtl/qam_slicer_serdes.sv
// Hard-decision QPSK/16-QAM slicer with Gray demap, word FIFO and MSB-first serializer.
// Optional low-confidence counter enabled by defining QAM_LOWCONF_EN.
module qam_slicer_serdes #(
    parameter int SAMPLE_W     = 8,
    parameter int BITS_PER_SYM = 2,
    parameter int THRESH       = 32,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic               CLOCK_256,
    input  logic               reset_n,
    qam_slicer_serdes_if.slave bus,
    output logic [15:0]        sym_count
`ifdef QAM_LOWCONF_EN
    ,
    output logic [15:0]        low_conf_count
`endif
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BC_W  = $clog2(BITS_PER_SYM);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(BITS_PER_SYM - 1);

    typedef logic [BITS_PER_SYM-1:0] word_t;
    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t           state_q, state_d;
    logic             slicer_valid_q, slicer_valid_d;
    word_t            word_q, word_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    word_t            shift_q, shift_d;
    logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic             bit_valid_q, bit_valid_d;
    logic [15:0]      sym_count_q, sym_count_d;
    word_t            mem_q [FIFO_DEPTH];

    word_t sliced;
    logic  accept, push, pop, last_hs;

    // Sign bit gives the half-plane; 16-QAM adds an inner/outer magnitude bit.
    if (BITS_PER_SYM == 4) begin : g_qam16
        localparam logic [SAMPLE_W:0] THRESH_V = THRESH[SAMPLE_W:0];
        logic [SAMPLE_W:0] ext_i, ext_q, mag_i, mag_q;
        assign ext_i  = {bus.I_in[SAMPLE_W-1], bus.I_in};
        assign ext_q  = {bus.Q_in[SAMPLE_W-1], bus.Q_in};
        assign mag_i  = bus.I_in[SAMPLE_W-1] ? (~ext_i + 1'b1) : ext_i;
        assign mag_q  = bus.Q_in[SAMPLE_W-1] ? (~ext_q + 1'b1) : ext_q;
        assign sliced = {bus.I_in[SAMPLE_W-1], mag_i >= THRESH_V,
                         bus.Q_in[SAMPLE_W-1], mag_q >= THRESH_V};
    end else begin : g_qpsk
        assign sliced = {bus.I_in[SAMPLE_W-1], bus.Q_in[SAMPLE_W-1]};
    end

    // Slicer stage occupies a slot, so it is counted against FIFO capacity.
    assign bus.in_ready  = (count_q + CNT_W'(slicer_valid_q)) < CNT_W'(FIFO_DEPTH);
    assign accept        = bus.in_valid && bus.in_ready;
    assign push          = slicer_valid_q;
    assign last_hs       = (state_q == S_SHIFT) && bus.bit_ready && (bit_cnt_q == '0);
    assign pop           = (count_q != '0) && ((state_q == S_IDLE) || last_hs);
    assign bus.bit_out   = shift_q[BITS_PER_SYM-1];
    assign bus.bit_valid = bit_valid_q;
    assign sym_count     = sym_count_q;

    always_comb begin
        slicer_valid_d = accept;
        word_d         = accept ? sliced : word_q;
        wr_ptr_d       = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d       = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d        = count_q + CNT_W'(push) - CNT_W'(pop);
        state_d        = state_q;
        shift_d        = shift_q;
        bit_cnt_d      = bit_cnt_q;
        sym_count_d    = sym_count_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    shift_d   = mem_q[rd_ptr_q];
                    bit_cnt_d = BC_LAST;
                    state_d   = S_SHIFT;
                end
            end
            default: begin
                if (bus.bit_ready) begin
                    shift_d   = shift_q << 1;
                    bit_cnt_d = bit_cnt_q - BC_W'(1);
                    if (bit_cnt_q == '0) begin
                        sym_count_d = sym_count_q + 16'd1;
                        // Reload straight from the FIFO so back-to-back words have no bubble.
                        if (pop) begin
                            shift_d   = mem_q[rd_ptr_q];
                            bit_cnt_d = BC_LAST;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end
        endcase
        bit_valid_d = (state_d == S_SHIFT);
    end

    always_ff @(posedge CLOCK_256) begin
        if (push) mem_q[wr_ptr_q] <= word_q;
    end

`ifdef QAM_LOWCONF_EN
    localparam int GUARD = THRESH / 4;
    logic        lc_hit_q, lc_hit_d;
    logic [15:0] lc_count_q, lc_count_d;

    function automatic logic near_boundary(input logic [SAMPLE_W-1:0] x);
        int a;
        a = int'($signed(x));
        if (a < 0) a = -a;
        near_boundary = (a <= GUARD) ||
            ((BITS_PER_SYM == 4) && (a - THRESH <= GUARD) && (THRESH - a <= GUARD));
    endfunction

    always_comb begin
        lc_hit_d   = accept && (near_boundary(bus.I_in) || near_boundary(bus.Q_in));
        lc_count_d = (lc_hit_q && lc_count_q != 16'hFFFF) ? lc_count_q + 16'd1 : lc_count_q;
    end

    always_ff @(posedge CLOCK_256 or negedge reset_n) begin
        if (!reset_n) begin
            lc_hit_q   <= 1'b0;
            lc_count_q <= '0;
        end else begin
            lc_hit_q   <= lc_hit_d;
            lc_count_q <= lc_count_d;
        end
    end

    assign low_conf_count = lc_count_q;
`endif

    always_ff @(posedge CLOCK_256 or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            slicer_valid_q <= 1'b0;
            word_q         <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            shift_q        <= '0;
            bit_cnt_q      <= '0;
            bit_valid_q    <= 1'b0;
            sym_count_q    <= '0;
        end else begin
            state_q        <= state_d;
            slicer_valid_q <= slicer_valid_d;
            word_q         <= word_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            shift_q        <= shift_d;
            bit_cnt_q      <= bit_cnt_d;
            bit_valid_q    <= bit_valid_d;
            sym_count_q    <= sym_count_d;
        end
    end
endmodule

// File: doc/qam_slicer_serdes.md
# qam_slicer_serdes

Parametrised successor to the fixed 2-bit QPSK demapper: a hard-decision QPSK/16-QAM slicer that takes signed I/Q samples under a valid/ready handshake and Gray-demaps each sample to a 2- or 4-bit symbol word. Words are buffered in a small FIFO and serialised MSB-first onto a valid/ready bit stream for the downstream deframer. Sits between the matched-filter/decimator and the bit-level receive chain in `CLOCK_256`.

## Interface
- `SAMPLE_W`, 8: width of signed two's-complement I/Q samples.
- `BITS_PER_SYM`, 2: 2 = QPSK, 4 = 16-QAM; other values illegal.
- `THRESH`, 32: 16-QAM inner/outer magnitude decision threshold; unused for QPSK except by the low-confidence option.
- `FIFO_DEPTH`, 4: symbol-word FIFO depth; power of 2, ≥2.

Ports:
- `CLOCK_256`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  sample present.
- `in_ready`  out  1  block can accept a sample.
- `I_in`  in  SAMPLE_W  signed in-phase sample.
- `Q_in`  in  SAMPLE_W  signed quadrature sample.
- `bit_out`  out  1  serial demodulated bit.
- `bit_valid`  out  1  `bit_out` valid.
- `bit_ready`  in  1  downstream accepts `bit_out`.
- `sym_count`  out  16  symbols fully delivered; wraps 0xFFFF→0.

## Operation
- Accept on `in_valid && in_ready`. `in_ready = (fifo_count + slicer_valid) < FIFO_DEPTH`, combinational from registered state.
- Per axis x: `s = x<0` (0 counts positive); `m = |x| >= THRESH`, with |x| computed in SAMPLE_W+1 bits so the most-negative value does not overflow.
- Gray per axis (16-QAM): +3→01, +1→00, −1→10, −3→11.
- QPSK word = `{sI, sQ}`; 16-QAM word = `{sI, mI, sQ, mQ}`.
- Stage 1: slicer register (word + `slicer_valid`). Stage 2: FIFO write next cycle.
- Serializer FSM:
  - IDLE: `bit_valid=0`. If FIFO non-empty, pop into shift register, load bit counter = BITS_PER_SYM−1 → SHIFT.
  - SHIFT: `bit_valid=1`, `bit_out` = shift MSB. On `bit_ready`, shift left and decrement counter.
  - On handshake of the last bit: `sym_count++`. If FIFO non-empty, pop and reload in the same cycle (no bubble, stay SHIFT); else → IDLE.
- `bit_out` holds stable while `bit_valid && !bit_ready`.
- FIFO write and pop in the same cycle: count unchanged; legal when full, because a pop frees the slot.
- Pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset (async, immediate): `bit_valid=0`, `bit_out=0`, `sym_count=0`, FIFO/slicer empty, FSM IDLE; `in_ready=1` from the empty state. Reset mid-symbol discards all buffered and partial symbols.
- Latency: sample accepted at edge N → FIFO at N+1 → first bit valid after edge N+2 (serializer idle).
- Throughput: one symbol per BITS_PER_SYM cycles with `bit_ready` held high.
- Capacity under stall: FIFO_DEPTH+1 symbols (one held in the serializer).

## Configuration
- `QAM_LOWCONF_EN` defined:
  - Adds output `low_conf_count` [15:0], reset 0.
  - Increments one cycle after each accepted sample whose I or Q lies within THRESH/4 of a decision boundary. Boundaries are 0 for QPSK; 0 and ±THRESH for 16-QAM.
  - Saturates at 0xFFFF.
- Undefined: port and logic absent; all other behaviour identical.

## Test plan
- QPSK, defaults: I=+40, Q=−40, `bit_ready=1` → bits 0,1 on consecutive cycles, first bit valid 2 cycles after accept, `sym_count`=1.
- 16-QAM, THRESH=32: I=−50, Q=+10 → bits 1,1,0,0. Boundary inputs I=−128, Q=0 → 1,1,0,0.
- Back-to-back: 8 QPSK samples with `bit_ready=1` → 16 bits, `bit_valid` continuous with no bubble, `sym_count`=8.
- Stall: `bit_ready=0`, `in_valid=1`, FIFO_DEPTH=4 → exactly 5 accepted, then `in_ready=0`. Release → all 5 words delivered in order, `in_ready` reasserts after the first pop.
- Reset: drive `reset_n` low while `bit_valid=1` mid-symbol → `bit_valid=0`, `sym_count=0` without a clock edge. After release, the next sample emerges with normal 2-cycle latency.
- `QAM_LOWCONF_EN`, QPSK: I=5, Q=+40 → `low_conf_count`=1. I=+40, Q=+40 → count unchanged.
